float_argmax_seq: RTL and testbench
===================================

// Module: float_argmax_seq
// PURPOSE
//  Sequencer that streams N_ELEM IEEE-754 single-precision values through one
//  comp_float comparator and reports the index and value of the maximum.
//  Sits at the output layer of the neural-net datapath: classifier scores go in,
//  the winning class index comes out. One comparison per accepted element.
// PARAMETERS
//  N_ELEM  10  number of values per scan (>=1)
//  IDX_W   4   width of index outputs; must satisfy 2**IDX_W >= N_ELEM
// PORTS
//  clk       in   1      rising-edge clock
//  reset     in   1      synchronous, active-high reset
//  start     in   1      begin a scan; sampled only in IDLE or DONE
//  in_valid  in   1      in_data holds a valid element
//  in_ready  out  1      block accepts in_data this cycle
//  in_data   in   32     float element {sign,exp[7:0],man[22:0]}
//  busy      out  1      high in FIRST and SCAN
//  done      out  1      one-cycle pulse: scan complete, results valid
//  max_idx   out  IDX_W  index (0-based) of the maximum element
//  max_val   out  32     value of the maximum element
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=0, busy=0, done=0, max_idx=0, max_val=0, count=0.
//  Accept: element transfers on a clk edge with in_valid&in_ready; nothing else
//   advances the count.
//  Compare: one comp_float instance, a=in_data, b=max_val register.
//   Flag 3'b100 (a>b) replaces the maximum; 3'b010 (equal) and 3'b001 (a<b) keep it.
//   Ties keep the lower index. -0.0 compares below +0.0.
//   NaN/Inf are not special-cased (raw field comparison).
//  FSM:
//   IDLE  -> FIRST on start. Clear count; done=0.
//   FIRST -> in_ready=1. On accept: max_val<=in_data, max_idx<=0, count<=1.
//            Then DONE if N_ELEM==1, else SCAN. No comparison is made.
//   SCAN  -> in_ready=1. On accept: if flag==3'b100 then max_val<=in_data and
//            max_idx<=count. count<=count+1.
//            When the accepted element has count==N_ELEM-1, go to DONE.
//   DONE  -> done=1 for exactly the entry cycle (registered pulse).
//            max_idx/max_val hold until the next accepted first element.
//            start in DONE goes to FIRST (back-to-back scans).
//            Without start, DONE stays in DONE with done=0.
//  Latency: done asserts on the cycle after the last element is accepted.
//   A scan with no stalls takes N_ELEM+1 cycles from the first accept.
//  in_valid gaps: hold state; no count change.
//  start while busy is ignored. in_data offered in IDLE/DONE is not accepted
//   (in_ready=0).
//  reset mid-scan: aborts to IDLE, all outputs return to reset values,
//   no done pulse.
//  count width IDX_W; never exceeds N_ELEM-1 (no wrap).
// TESTING
//  1 Reset then scores {1.0,3.5,-2.0,3.0} (N_ELEM=4), contiguous valid
//    -> done 1 cycle after 4th accept; max_idx=1; max_val=32'h40600000.
//  2 All-equal 2.0 x N_ELEM -> max_idx=0 (first wins); max_val=32'h40000000.
//  3 Mixed signs {-1.0,-0.0,+0.0,-5.0} -> max_idx=2 (+0.0 beats -0.0);
//    all-negative {-3.0,-1.0,-2.0,-4.0} -> max_idx=1.
//  4 in_valid toggled 1/0 every cycle, max last {0.5,0.25,0.1,9.0}
//    -> in_ready high throughout the scan, count advances only on accepts,
//    max_idx=3, done once.
//  5 reset asserted after 2 accepts -> next cycle IDLE, busy=0, max_idx=0,
//    no done. New start + {7.0,1.0,1.0,1.0} -> max_idx=0.
//  6 start pulsed in the done cycle, plus start while busy -> second scan
//    begins immediately; start while busy has no effect; N_ELEM=1 build ->
//    done 1 cycle after the single accept, max_idx=0.

Source files
------------

// File: rtl/float_argmax_seq.sv
// rtl/float_argmax_seq.sv - streaming argmax over N_ELEM single-precision floats
// Holds a running maximum and its index; one comp_float comparison per accepted element.

module comp_float (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [2:0]  flag
);
  // Sign-magnitude ordering on raw fields, so -0.0 sorts below +0.0.
  always_comb begin
    flag = 3'b010;
    if (a != b) begin
      if (a[31] != b[31]) begin
        flag = a[31] ? 3'b001 : 3'b100;
      end else if (!a[31]) begin
        flag = (a[30:0] > b[30:0]) ? 3'b100 : 3'b001;
      end else begin
        flag = (a[30:0] > b[30:0]) ? 3'b001 : 3'b100;
      end
    end
  end
endmodule

module float_argmax_seq #(
  parameter int N_ELEM = 10,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] max_idx,
  output logic [31:0]      max_val
);
  typedef enum logic [1:0] {IDLE, FIRST, SCAN, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_ELEM - 1);

  state_t           state, next_state;
  logic [IDX_W-1:0] count;
  logic [2:0]       flag;
  logic             accept;

  comp_float u_cmp (
    .a    (in_data),
    .b    (max_val),
    .flag (flag)
  );

  assign in_ready = (state == FIRST) || (state == SCAN);
  assign busy     = in_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = FIRST;
      FIRST:   if (accept) next_state = (N_ELEM == 1) ? DONE : SCAN;
      SCAN:    if (accept && count == LAST) next_state = DONE;
      DONE:    if (start) next_state = FIRST;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      done    <= 1'b0;
      count   <= '0;
      max_idx <= '0;
      max_val <= '0;
    end else begin
      state <= next_state;
      done  <= (next_state == DONE) && (state != DONE);
      if ((state == IDLE || state == DONE) && start) begin
        count <= '0;
      end
      if (state == FIRST && accept) begin
        max_val <= in_data;
        max_idx <= '0;
        count   <= (N_ELEM == 1) ? '0 : IDX_W'(1);
      end
      if (state == SCAN && accept) begin
        if (flag == 3'b100) begin
          max_val <= in_data;
          max_idx <= count;
        end
        // Count saturates at the last index; the scan ends there anyway.
        if (count != LAST) count <= count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_float_argmax_seq.sv
// tb/tb_float_argmax_seq.sv - self-checking bench for float_argmax_seq
// Running-argmax model checked every cycle, plus literal expectations per scan.

module tb_float_argmax_seq;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [31:0] in_data;
  logic        in_ready, busy, done;
  logic [3:0]  max_idx;
  logic [31:0] max_val;

  logic        s_start, s_valid;
  logic [31:0] s_data;
  logic        s_ready, s_busy, s_done;
  logic [0:0]  s_idx;
  logic [31:0] s_val;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  float_argmax_seq #(.N_ELEM(N), .IDX_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .busy(busy), .done(done),
    .max_idx(max_idx), .max_val(max_val)
  );

  float_argmax_seq #(.N_ELEM(1), .IDX_W(1)) dut1 (
    .clk(clk), .reset(reset), .start(s_start), .in_valid(s_valid),
    .in_ready(s_ready), .in_data(s_data), .busy(s_busy), .done(s_done),
    .max_idx(s_idx), .max_val(s_val)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monotonic unsigned key for IEEE sign-magnitude ordering.
  function automatic logic [31:0] fkey(input logic [31:0] b);
    return b[31] ? ~b : (b | 32'h8000_0000);
  endfunction

  logic [31:0] m_q[$];
  bit          m_active, m_done, m_ok;
  logic [3:0]  m_idx;
  logic [31:0] m_val;

  always @(posedge clk) begin
    if (reset) begin
      m_active = 0; m_done = 0; m_idx = 0; m_val = 0; m_ok = 1;
      m_q.delete();
    end else begin
      m_done = 0;
      if (!m_active && start) begin
        m_active = 1;
        m_q.delete();
      end else if (m_active && in_valid) begin
        m_q.push_back(in_data);
        m_idx = 0;
        m_val = m_q[0];
        for (int i = 1; i < m_q.size(); i++)
          if (fkey(m_q[i]) > fkey(m_val)) begin
            m_idx = 4'(i);
            m_val = m_q[i];
          end
        if (m_q.size() == N) begin
          m_active = 0;
          m_done = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, m_active});
      chk("busy", {31'b0, busy}, {31'b0, m_active});
      chk("done", {31'b0, done}, {31'b0, m_done});
      chk("max_idx", {28'b0, max_idx}, {28'b0, m_idx});
      chk("max_val", max_val, m_val);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [31:0] v[4], input bit do_start, input bit gaps,
                      input bit chain, input logic [3:0] e_idx, input logic [31:0] e_val,
                      input string tag);
    if (do_start) begin
      start = 1; tick(); start = 0;
    end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_data = v[i];
      if (gaps && i == 1) start = 1;
      tick();
      start = 0; in_valid = 0; in_data = 32'hDEAD_BEEF;
      if (gaps) tick();
    end
    if (gaps) begin
      chk({tag, "_done_late"}, {31'b0, done}, 32'd0);
    end else begin
      chk({tag, "_done"}, {31'b0, done}, 32'd1);
      chk({tag, "_idx"}, {28'b0, max_idx}, {28'b0, e_idx});
      chk({tag, "_val"}, max_val, e_val);
    end
    if (chain) start = 1;
  endtask

  logic [31:0] v[4];

  initial begin
    m_ok = 0;
    reset = 1; start = 0; in_valid = 0; in_data = 0;
    s_start = 0; s_valid = 0; s_data = 0;
    tick(); tick();
    reset = 0;
    chk("rst_idx", {28'b0, max_idx}, 32'd0);
    chk("rst_val", max_val, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd0);

    in_valid = 1; in_data = 32'h4100_0000; tick(); tick();
    chk("idle_ready", {31'b0, in_ready}, 32'd0);
    in_valid = 0;

    v = '{32'h3F80_0000, 32'h4060_0000, 32'hC000_0000, 32'h4040_0000};
    scan(v, 1, 0, 0, 4'd1, 32'h4060_0000, "t1");
    tick();
    chk("t1_pulse", {31'b0, done}, 32'd0);
    chk("t1_hold", max_val, 32'h4060_0000);

    v = '{32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000};
    scan(v, 1, 0, 0, 4'd0, 32'h4000_0000, "t2");
    tick();
    v = '{32'hBF80_0000, 32'h8000_0000, 32'h0000_0000, 32'hC0A0_0000};
    scan(v, 1, 0, 0, 4'd2, 32'h0000_0000, "t3a");
    tick();
    v = '{32'hC040_0000, 32'hBF80_0000, 32'hC000_0000, 32'hC080_0000};
    scan(v, 1, 0, 0, 4'd1, 32'hBF80_0000, "t3b");
    tick();

    v = '{32'h3F00_0000, 32'h3E80_0000, 32'h3DCC_CCCD, 32'h4110_0000};
    scan(v, 1, 1, 0, 4'd3, 32'h4110_0000, "t4");
    chk("t4_idx", {28'b0, max_idx}, 32'd3);
    chk("t4_val", max_val, 32'h4110_0000);

    start = 1; tick(); start = 0;
    in_valid = 1; in_data = 32'h4200_0000; tick(); tick();
    in_valid = 0; reset = 1; tick(); reset = 0;
    chk("t5_busy", {31'b0, busy}, 32'd0);
    chk("t5_idx", {28'b0, max_idx}, 32'd0);
    chk("t5_done", {31'b0, done}, 32'd0);
    v = '{32'h40E0_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
    scan(v, 1, 0, 0, 4'd0, 32'h40E0_0000, "t5");

    v = '{32'h3F80_0000, 32'h3F80_0000, 32'h4040_0000, 32'h3F80_0000};
    scan(v, 1, 0, 1, 4'd2, 32'h4040_0000, "t6a");
    tick(); start = 0;
    v = '{32'hC000_0000, 32'h3F00_0000, 32'hC040_0000, 32'h3F00_0000};
    scan(v, 0, 0, 0, 4'd1, 32'h3F00_0000, "t6b");
    tick();

    s_start = 1; tick(); s_start = 0;
    chk("n1_busy", {31'b0, s_busy}, 32'd1);
    s_valid = 1; s_data = 32'h4080_0000; tick(); s_valid = 0;
    chk("n1_done", {31'b0, s_done}, 32'd1);
    chk("n1_idx", {31'b0, s_idx}, 32'd0);
    chk("n1_val", s_val, 32'h4080_0000);
    tick();
    chk("n1_pulse", {31'b0, s_done}, 32'd0);
    chk("n1_ready", {31'b0, s_ready}, 32'd0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
